// File: rtl/px_seq_pkg.sv
// Shared types and helpers for the px_seq processor state sequencer.
package px_seq_pkg;

    localparam int PX_MAXW          = 64;
    localparam int DEF_STROB2_TICKS = 3;
    localparam int DEF_GOT_TICKS    = 2;
    localparam int DEF_ALARM_TICKS  = 200;

    typedef enum logic [2:0] {
        PH_S1,
        PH_WAIT,
        PH_HOLD,
        PH_S2,
        PH_GOT
    } px_phase_t;

    typedef struct packed {
        logic [PX_MAXW-1:0] vec;
        logic               multi;
    } px_onehot_t;

    // Isolate the lowest set bit (two's complement trick) and flag any extra bits.
    function automatic px_onehot_t lowest_onehot(input logic [PX_MAXW-1:0] v);
        px_onehot_t r;
        r.vec   = v & (~v + PX_MAXW'(1));
        r.multi = |(v & ~r.vec);
        return r;
    endfunction

endpackage

// File: rtl/px_seq_if.sv
// Handshake bundle between state decode / datapath and the px_seq sequencer.
interface px_seq_if #(
    parameter int NSTATES = 32
);
    logic [NSTATES-1:0] enter;
    logic               zw;
    logic               ok;
    logic               oken;
    logic               mode;
    logic               step;
    logic [NSTATES-1:0] state;
    logic               strob1;
    logic               strob2;
    logic               got;
    logic               busy;
    logic               alarm;
    logic               err_onehot;

    modport master (
        output enter, zw, ok, oken, mode, step,
        input  state, strob1, strob2, got, busy, alarm, err_onehot
    );

    modport slave (
        input  enter, zw, ok, oken, mode, step,
        output state, strob1, strob2, got, busy, alarm, err_onehot
    );
endinterface

// File: rtl/px_seq_timer.sv
// Loadable saturating down-counter; last is high once the count reaches zero.
module px_seq_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [TW-1:0] ld_val,
    output logic [TW-1:0] cnt,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= ld_val;
        else if (en && cnt != '0)
            cnt <= cnt - TW'(1);
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/px_seq.sv
// One-hot processor state register plus strob1/strob2/got phase sequencer
// with bus-wait, single-step hold and bus timeout alarm.
module px_seq
    import px_seq_pkg::*;
#(
    parameter int                   NSTATES      = 32,
    parameter int                   NCLASS       = 5,
    parameter int                   CW           = 3,
    parameter int                   TW           = 8,
    parameter logic [NSTATES*CW-1:0] STATE_CLASS = '0,
    parameter logic [NSTATES-1:0]   BUS_MASK     = '0,
    parameter logic [NCLASS-1:0]    S2_MASK      = '1,
    parameter logic [NCLASS*TW-1:0] STROB1_TICKS = {NCLASS{TW'(1)}},
    parameter int                   STROB2_TICKS = DEF_STROB2_TICKS,
    parameter int                   GOT_TICKS    = DEF_GOT_TICKS,
    parameter int                   ALARM_TICKS  = DEF_ALARM_TICKS,
    parameter int                   RESET_STATE  = 0
) (
    input  logic      clk,
    input  logic      clo,
    px_seq_if.slave   bus
);

    localparam logic [NSTATES-1:0] RST_VEC  = NSTATES'(1) << RESET_STATE;
    localparam logic [TW-1:0]      S2_LD    = TW'((STROB2_TICKS == 0) ? 0 : STROB2_TICKS - 1);
    localparam logic [TW-1:0]      GOT_LD   = TW'((GOT_TICKS == 0) ? 0 : GOT_TICKS - 1);
    localparam logic [TW-1:0]      ALARM_LD = TW'(ALARM_TICKS);

    function automatic logic [CW-1:0] class_of(input logic [NSTATES-1:0] st);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NSTATES; i++)
            if (st[i]) c |= STATE_CLASS[i*CW +: CW];
        return c;
    endfunction

    // Timer holds length-1, so a programmed 0 behaves like 1.
    function automatic logic [TW-1:0] s1_ld(input logic [CW-1:0] c);
        logic [TW-1:0] t;
        if (int'(c) < NCLASS) t = STROB1_TICKS[int'(c)*TW +: TW];
        else                  t = TW'(1);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    px_phase_t          phase_q, phase_d;
    px_phase_t          after_s1, after_wait, after_hold;
    logic [NSTATES-1:0] state_q, state_d;
    logic               run_q;
    logic               step_q, step_rise;
    logic               hs, is_bus, s2_en;
    logic [CW-1:0]      cls_q;
    logic               err_d, alarm_d;
    logic               strob1_q, strob2_q, got_q, busy_q, alarm_q, err_q;
    px_onehot_t         ent;

    logic               tmr_load, tmr_last;
    logic [TW-1:0]      tmr_ld, tmr_cnt;

    px_seq_timer #(.TW(TW)) u_tmr (
        .clk    (clk),
        .rst    (clo),
        .load   (tmr_load),
        .en     (1'b1),
        .ld_val (tmr_ld),
        .cnt    (tmr_cnt),
        .last   (tmr_last)
    );

    assign ent       = lowest_onehot(PX_MAXW'(bus.enter));
    assign cls_q     = class_of(state_q);
    assign is_bus    = |(state_q & BUS_MASK);
    assign s2_en     = (int'(cls_q) < NCLASS) ? S2_MASK[cls_q] : 1'b1;
    assign hs        = bus.zw & bus.oken & bus.ok;
    assign step_rise = bus.step & ~step_q;

    assign after_hold = s2_en    ? PH_S2   : PH_GOT;
    assign after_wait = bus.mode ? PH_HOLD : after_hold;
    assign after_s1   = is_bus   ? PH_WAIT : after_wait;

    always_comb begin
        phase_d = phase_q;
        state_d = state_q;
        err_d   = 1'b0;
        if (!run_q) begin
            phase_d = PH_S1;
        end else begin
            unique case (phase_q)
                PH_S1:   if (tmr_last)        phase_d = after_s1;
                PH_WAIT: if (hs || tmr_last)  phase_d = after_wait;
                PH_HOLD: if (step_rise)       phase_d = after_hold;
                PH_S2:   if (tmr_last)        phase_d = PH_GOT;
                PH_GOT: begin
                    if (tmr_last) begin
                        phase_d = PH_S1;
                        state_d = (|bus.enter) ? ent.vec[NSTATES-1:0] : RST_VEC;
                        err_d   = ent.multi;
                    end
                end
                default: phase_d = PH_S1;
            endcase
        end
    end

    always_comb begin
        tmr_load = (phase_d != phase_q) || !run_q;
        tmr_ld   = '0;
        unique case (phase_d)
            PH_S1:   tmr_ld = s1_ld(class_of(state_d));
            PH_WAIT: tmr_ld = ALARM_LD;
            PH_S2:   tmr_ld = S2_LD;
            PH_GOT:  tmr_ld = GOT_LD;
            default: tmr_ld = '0;
        endcase
    end

    // Alarm is registered, so it is raised on the edge entering the final WAIT cycle.
    always_comb begin
        alarm_d = 1'b0;
        if (phase_d == PH_WAIT) begin
            if (phase_q != PH_WAIT) alarm_d = (ALARM_TICKS == 0);
            else                    alarm_d = (tmr_cnt == TW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (clo) begin
            phase_q  <= PH_S1;
            state_q  <= RST_VEC;
            run_q    <= 1'b0;
            step_q   <= 1'b1;
            strob1_q <= 1'b0;
            strob2_q <= 1'b0;
            got_q    <= 1'b0;
            busy_q   <= 1'b1;
            alarm_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            state_q  <= state_d;
            run_q    <= 1'b1;
            step_q   <= bus.step;
            strob1_q <= (phase_d == PH_S1);
            strob2_q <= (phase_d == PH_S2);
            got_q    <= (phase_d == PH_GOT);
            busy_q   <= (phase_d != PH_HOLD);
            alarm_q  <= alarm_d;
            err_q    <= err_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.strob1     = strob1_q;
    assign bus.strob2     = strob2_q;
    assign bus.got        = got_q;
    assign bus.busy       = busy_q;
    assign bus.alarm      = alarm_q;
    assign bus.err_onehot = err_q;

endmodule

// File: tb/tb_px_seq.sv
// Directed-vector bench for px_seq: reset, bus wait, class timing, timeout,
// single step, enter resolution and clo aborts.
module tb_px_seq;

    logic clk = 1'b0;
    logic clo;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    px_seq_if #(.NSTATES(32)) bus ();

    // state 4 is class 1 (2-tick strob1, no strob2); state 3 is a bus state
    px_seq #(
        .NSTATES      (32),
        .NCLASS       (5),
        .CW           (3),
        .TW           (8),
        .STATE_CLASS  (96'h1000),
        .BUS_MASK     (32'h8),
        .S2_MASK      (5'b11101),
        .STROB1_TICKS ({8'd1, 8'd1, 8'd1, 8'd2, 8'd1}),
        .STROB2_TICKS (3),
        .GOT_TICKS    (2),
        .ALARM_TICKS  (10),
        .RESET_STATE  (0)
    ) dut (
        .clk (clk),
        .clo (clo),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] obs();
        return {bus.state, bus.strob1, bus.strob2, bus.got, bus.busy, bus.alarm, bus.err_onehot};
    endfunction

    function automatic logic [37:0] mk(input logic [31:0] st, input logic [2:0] sg,
                                       input logic b, input logic a, input logic e);
        return {st, sg, b, a, e};
    endfunction

    // Strobe pattern {strob1,strob2,got} of a class-0 non-bus cycle, position p.
    function automatic logic [2:0] pat(input int p);
        if (p == 0) return 3'b100;
        if (p <= 3) return 3'b010;
        return 3'b001;
    endfunction

    task automatic test_reset();
        logic [37:0] exp;
        clo = 1'b1; bus.enter = '0; bus.zw = 0; bus.ok = 0; bus.oken = 0;
        bus.mode = 0; bus.step = 0;
        repeat (3) tick();
        exp = mk(32'h1, 3'b000, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL reset_hold: got %h want %h", obs(), exp); end
        nvec++;
        bus.enter = 32'h4; clo = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = mk(32'h1, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL reset_seq[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        tick();
        exp = mk(32'h4, 3'b100, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL reset_next: got %h want %h", obs(), exp); end
        nvec++;
    endtask

    task automatic test_bus_wait();
        logic [37:0] exp;
        bus.enter = 32'h8;
        for (int i = 1; i < 6; i++) begin
            tick();
            exp = mk(32'h4, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL bus_pre[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        tick();
        exp = mk(32'h8, 3'b100, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL bus_s1: got %h want %h", obs(), exp); end
        nvec++;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = mk(32'h8, 3'b000, 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL bus_wait[%0d]: got %h want %h", k, obs(), exp); end
            nvec++;
            // partial handshakes first, full one only in WAIT cycle 5
            bus.zw   = (k == 2 || k >= 4);
            bus.ok   = (k == 2 || k == 3 || k == 5);
            bus.oken = (k >= 3);
        end
        bus.enter = 32'h10;
        for (int i = 1; i < 6; i++) begin
            tick();
            bus.zw = 0; bus.ok = 0; bus.oken = 0;
            exp = mk(32'h8, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL bus_post[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        tick();
        exp = mk(32'h10, 3'b100, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL bus_next: got %h want %h", obs(), exp); end
        nvec++;
    endtask

    task automatic test_class();
        logic [37:0] exp;
        logic [2:0]  seq [3] = '{3'b100, 3'b001, 3'b001};
        bus.enter = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = mk(32'h10, seq[i], 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL class1[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        tick();
        exp = mk(32'h8, 3'b100, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL class1_next: got %h want %h", obs(), exp); end
        nvec++;
    endtask

    task automatic test_timeout();
        logic [37:0] exp;
        bus.enter = 32'h20;
        for (int k = 0; k <= 10; k++) begin
            tick();
            exp = mk(32'h8, 3'b000, 1, (k == 10), 0);
            if (obs() !== exp) begin nerr++; $display("FAIL timeout_wait[%0d]: got %h want %h", k, obs(), exp); end
            nvec++;
        end
        for (int i = 1; i < 6; i++) begin
            tick();
            exp = mk(32'h8, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL timeout_post[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        tick();
        exp = mk(32'h20, 3'b100, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL timeout_next: got %h want %h", obs(), exp); end
        nvec++;
    endtask

    task automatic test_step();
        logic [37:0] exp;
        bus.mode = 1; bus.enter = 32'h1;
        for (int h = 0; h < 50; h++) begin
            tick();
            exp = mk(32'h20, 3'b000, 0, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL step_hold[%0d]: got %h want %h", h, obs(), exp); end
            nvec++;
        end
        bus.step = 1;
        for (int i = 1; i < 6; i++) begin
            tick();
            exp = mk(32'h20, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL step_go[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        tick();
        exp = mk(32'h1, 3'b100, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL step_next: got %h want %h", obs(), exp); end
        nvec++;
        for (int h = 0; h < 11; h++) begin
            if (h == 10) bus.step = 0;
            tick();
            exp = mk(32'h1, 3'b000, 0, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL step_held[%0d]: got %h want %h", h, obs(), exp); end
            nvec++;
        end
        bus.mode = 0; bus.step = 1; bus.enter = 32'h0A;
        for (int i = 1; i < 6; i++) begin
            tick();
            exp = mk(32'h1, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL step_go2[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
    endtask

    task automatic test_enter_err();
        logic [37:0] exp;
        tick();
        exp = mk(32'h2, 3'b100, 1, 0, 1);
        if (obs() !== exp) begin nerr++; $display("FAIL enter_multi: got %h want %h", obs(), exp); end
        nvec++;
        bus.enter = '0;
        for (int i = 1; i < 6; i++) begin
            tick();
            exp = mk(32'h2, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL enter_run[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        tick();
        exp = mk(32'h1, 3'b100, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL enter_zero: got %h want %h", obs(), exp); end
        nvec++;
    endtask

    task automatic test_clo();
        logic [37:0] exp;
        bus.enter = 32'h8;
        for (int i = 1; i < 6; i++) begin
            tick();
            exp = mk(32'h1, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL clo_pre[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        for (int k = -1; k < 3; k++) begin
            tick();
            exp = mk(32'h8, (k < 0) ? 3'b100 : 3'b000, 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL clo_wait[%0d]: got %h want %h", k, obs(), exp); end
            nvec++;
        end
        clo = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = mk(32'h1, 3'b000, 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL clo_wait_rst[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        clo = 0; bus.enter = 32'h1;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp = mk(32'h1, pat(i % 6), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL clo_after[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
        clo = 1;
        tick();
        exp = mk(32'h1, 3'b000, 1, 0, 0);
        if (obs() !== exp) begin nerr++; $display("FAIL clo_got_rst: got %h want %h", obs(), exp); end
        nvec++;
        clo = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = mk(32'h1, pat(i), 1, 0, 0);
            if (obs() !== exp) begin nerr++; $display("FAIL clo_got_after[%0d]: got %h want %h", i, obs(), exp); end
            nvec++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bus_wait();
        test_class();
        test_timeout();
        test_step();
        test_enter_err();
        test_clo();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/px_seq.md
# px_seq

Parametrised, fully synchronous successor of the processor state-control sequencer. It holds the one-hot processor state vector (K, P, W, I states) and generates the strob1 / strob2 / got strobe sequence for each state. Strobe lengths are set per timing class, and any state can be marked as a bus state that must wait for the system-bus handshake. It sits between the state-decode logic, which supplies the enter-state vector, and the datapath, which consumes the state and the strobes. Single-step mode and a bus-timeout alarm are built in.

## Interface
- NSTATES, 32, number of one-hot states
- NCLASS, 5, number of strob1 timing classes
- CW, 3, class index width (≥ clog2(NCLASS))
- TW, 8, tick counter width
- STATE_CLASS, 0, packed NSTATES×CW: timing class of each state
- BUS_MASK, 0, NSTATES bits: state waits for bus handshake after strob1
- S2_MASK, all ones, NCLASS bits: class has a strob2 phase
- STROB1_TICKS, all 1, packed NCLASS×TW: strob1 length per class
- STROB2_TICKS, 3, strob2 length
- GOT_TICKS, 2, got length
- ALARM_TICKS, 200, bus wait timeout
- RESET_STATE, 0, state index loaded on reset or empty enter vector

Ports:
- __clk  in  1  system clock
- clo  in  1  general clear; synchronous, active-high
- enter  in  NSTATES  next-state request vector, sampled at the end of got
- zw  in  1  CPU granted the system bus
- ok  in  1  bus transaction accepted
- oken  in  1  bus response (ok or en) present
- mode  in  1  single-step mode
- step  in  1  step key (level; rising edge used)
- state  out  NSTATES  current one-hot state
- strob1, strob2, got  out  1  phase strobes
- busy  out  1  sequencer not in a step hold
- alarm  out  1  one-cycle pulse on bus timeout
- err_onehot  out  1  one-cycle pulse when enter was multi-hot

## Operation
- Phases: S1 → [WAIT] → [HOLD] → [S2] → GOT → S1.
- S1: strob1 = 1 for STROB1_TICKS[class(state)] cycles.
- WAIT: entered only if BUS_MASK[state]. Exit when zw & oken & ok are all 1 in the same cycle. If none arrives within ALARM_TICKS cycles: pulse alarm and exit anyway.
- HOLD: entered only if mode = 1. busy = 0. Exit on the cycle after a step rising edge.
- S2: entered only if S2_MASK[class(state)]. strob2 = 1 for STROB2_TICKS cycles.
- GOT: got = 1 for GOT_TICKS cycles. On the last got cycle, state loads the resolved enter vector:
  - enter = 0 → state = 1 << RESET_STATE.
  - enter multi-hot → lowest set index wins; err_onehot pulses.
- Ticks value 0 is treated as 1; phase counters use TW bits and never wrap.
- clo (wins over everything):
  - state = 1 << RESET_STATE, phase = S1, counters reloaded.
  - All strobes 0, alarm 0, err_onehot 0, busy 1.
  - S1 begins on the first cycle after clo deasserts.
- mode changing mid-cycle takes effect at the next HOLD decision point, i.e. the end of S1/WAIT.
- step edges outside HOLD are ignored. The step edge detector reset value is step_q = 1, so a key held through reset does not step.

## Timing
- All outputs are registered; strobes change only on __clk edges.
- At most one strobe is high at a time, with no gap cycles between phases.
- Non-bus state cycle length: S1 + S2 + GOT cycles; default class-0 = 1 + 3 + 2 = 6.
- WAIT adds N+1 cycles, where the handshake is seen in WAIT cycle N (first WAIT cycle = 0).
- WAIT timeout: alarm goes high in WAIT cycle ALARM_TICKS; the next phase starts on the following cycle.
- state changes on the same edge that drops got; the new strob1 rises on that same edge.

## Structure
- Package px_seq_pkg holds:
  - phase enum (S1, WAIT, HOLD, S2, GOT)
  - function `lowest_onehot(vec)` returning the priority-resolved vector plus a multi-hot flag
  - default tick constants
- One sub-module, px_seq_timer: loadable TW-bit down-counter with load, enable, and a `last` flag. It is instantiated once and reloaded per phase.

## Test plan
- Reset: clo = 1 for 3 cycles → state = 1, all strobes 0, busy = 1. After release, strob1 high 1 cycle, then strob2 3, then got 2. With enter = 0x4, state = 0x4 after got.
- Bus wait: state class with BUS_MASK set, ok = oken = zw = 1 at WAIT cycle 5 → strob2 starts 6 cycles after strob1 falls; alarm stays 0.
- Timeout: ALARM_TICKS = 10, no ok → alarm pulses exactly once at WAIT cycle 10, then S2 and GOT proceed; the next state is loaded normally.
- Step: mode = 1 → busy drops after S1 and the sequencer stays in HOLD for 50 cycles. A step rising edge → strob2 on the next cycle. A step held high does not re-trigger.
- Enter errors: enter = 0x0A → state = 0x02 and err_onehot pulses on the got-end edge. enter = 0 → state = 1 << RESET_STATE.
- clo asserted during WAIT and during GOT → immediate return to reset values; no got or alarm pulse is emitted afterward for the aborted cycle.
